// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and flush FSM encoding for the store buffer
package store_buffer_pkg;
  localparam int SB_DATA_W = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_MAX_STALL = 4;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} flush_state_e;
endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: finds the youngest valid entry whose address equals the load address
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DataWidth = SB_DATA_W,
  parameter int Depth = SB_DEPTH
) (
  input  logic [Depth-1:0]         i_valid,
  input  logic [DataWidth-1:0]     i_addr [Depth],
  input  logic [$clog2(Depth)-1:0] i_tail,
  input  logic [DataWidth-1:0]     i_ld_addr,
  output logic                     o_hit,
  output logic [$clog2(Depth)-1:0] o_idx
);
  localparam int PtrW = $clog2(Depth);
  logic [PtrW-1:0] w_idx;
  // walk oldest (tail-Depth) to youngest (tail-1) so the last match wins
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_idx = '0;
    for (int k = Depth; k >= 1; k--) begin
      w_idx = i_tail - PtrW'(k);
      if (i_valid[w_idx] && i_addr[w_idx] == i_ld_addr) begin
        o_hit = 1'b1;
        o_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO ahead of data memory with load forwarding and flush
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DataWidth = SB_DATA_W,
  parameter int Depth = SB_DEPTH,
  parameter int MaxStall = SB_MAX_STALL
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     st_valid,
  input  logic [DataWidth-1:0]     st_addr,
  input  logic [DataWidth-1:0]     st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [DataWidth-1:0]     ld_addr,
  output logic                     ld_ready,
  output logic [DataWidth-1:0]     ld_data,
  output logic                     ld_hit,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic [DataWidth-1:0]     mem_addr,
  output logic [DataWidth-1:0]     mem_wdata,
  output logic                     mem_we,
  input  logic [DataWidth-1:0]     mem_rdata,
  output logic [$clog2(Depth):0]   count
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam int StW = $clog2(MaxStall + 1);
  logic [DataWidth-1:0] r_addr [Depth];
  logic [DataWidth-1:0] r_data [Depth];
  logic [Depth-1:0]     r_valid;
  logic [PtrW-1:0]      r_head, r_tail, w_idx;
  logic [CntW-1:0]      r_count;
  logic [StW-1:0]       r_stall;
  flush_state_e         r_state, w_state_nxt;
  logic w_hit, w_empty, w_full, w_force, w_drain, w_acc;

  store_buffer_match #(.DataWidth(DataWidth), .Depth(Depth)) u_match (
    .i_valid(r_valid), .i_addr(r_addr), .i_tail(r_tail), .i_ld_addr(ld_addr),
    .o_hit(w_hit), .o_idx(w_idx)
  );

  assign w_empty    = r_count == '0;
  assign w_full     = r_count == CntW'(Depth);
  assign flush_busy = r_state == DRAIN;
  assign st_ready   = !w_full && !flush_busy;
  assign w_acc      = st_valid && st_ready;
  assign ld_hit     = ld_valid && w_hit;
  // after MaxStall starved cycles the drain takes the port from a missing load
  assign w_force    = !w_empty && r_stall == StW'(MaxStall);
  assign w_drain    = !w_empty && (!ld_valid || ld_hit || w_force);
  assign ld_ready   = ld_hit || !w_force;
  assign ld_data    = ld_hit ? r_data[w_idx] : mem_rdata;
  assign mem_we     = w_drain;
  assign mem_addr   = w_drain ? r_addr[r_head] : ld_addr;
  assign mem_wdata  = w_drain ? r_data[r_head] : '0;
  assign count      = r_count;

  always_comb begin
    w_state_nxt = (r_state == IDLE) ? ((flush && !w_empty) ? DRAIN : IDLE)
                                    : (w_empty ? IDLE : DRAIN);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= '0;
      r_valid <= '0;
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_count <= r_count + CntW'(w_acc) - CntW'(w_drain);
      r_stall <= w_drain ? '0 : (w_empty ? r_stall : r_stall + StW'(1));
      if (w_drain) begin
        r_head <= r_head + PtrW'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (w_acc) begin
        r_tail <= r_tail + PtrW'(1);
        r_valid[r_tail] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer against a queue-based reference model
module tb_store_buffer;
  localparam int DW = 32, DEPTH = 4, MAXS = 4;
  logic clk = 0, RST = 0;
  logic st_valid = 0, ld_valid = 0, flush = 0;
  logic [DW-1:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic st_ready, ld_ready, ld_hit, flush_busy, mem_we;
  logic [DW-1:0] ld_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] count;
  logic [DW-1:0] bmem [256];
  logic [DW-1:0] mm [256];

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic hit; logic [31:0] d;} ld_t;
  typedef struct {logic st_ready; logic busy; logic lv; logic ldr; logic [2:0] cnt;} stat_t;
  wr_t wq[$];
  ld_t lq[$];
  stat_t sq[$];
  wr_t sbq[$];
  int stall = 0;
  bit fbusy = 0;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .RST(RST), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_hit(ld_hit), .flush(flush), .flush_busy(flush_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .count(count)
  );

  assign mem_rdata = bmem[mem_addr[7:0]];
  always @(posedge clk) if (RST && mem_we) bmem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(string name);
    total++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  always @(negedge clk) if (RST) begin
    stat_t s;
    ld_t l;
    wr_t w;
    if (sq.size() == 0) unexpected("status");
    else begin
      s = sq.pop_front();
      chk("st_ready", st_ready, s.st_ready);
      chk("count", count, s.cnt);
      chk("flush_busy", flush_busy, s.busy);
      if (s.lv) chk("ld_ready", ld_ready, s.ldr);
    end
    if (ld_valid && ld_ready) begin
      if (lq.size() == 0) unexpected("load");
      else begin
        l = lq.pop_front();
        chk("ld_hit", ld_hit, l.hit);
        chk("ld_data", ld_data, l.d);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) unexpected("mem_write");
      else begin
        w = wq.pop_front();
        chk("mem_addr", mem_addr, w.a);
        chk("mem_wdata", mem_wdata, w.d);
      end
    end
  end

  // called just after a rising edge; drives one cycle and advances the model
  task automatic step(bit sv, logic [31:0] sa, logic [31:0] sd, bit lv, logic [31:0] la, bit fl);
    int n = sbq.size();
    bit hit = 0, force_d, drain, ldr, acc;
    logic [31:0] hd = 0;
    stat_t s;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; flush = fl;
    for (int i = 0; i < n; i++) if (lv && sbq[i].a == la) begin hit = 1; hd = sbq[i].d; end
    force_d = n > 0 && stall == MAXS;
    drain = n > 0 && (!lv || hit || force_d);
    ldr = hit || !force_d;
    acc = sv && n < DEPTH && !fbusy;
    s = '{st_ready: (n < DEPTH && !fbusy), busy: fbusy, lv: lv, ldr: ldr, cnt: 3'(n)};
    sq.push_back(s);
    if (lv && ldr) lq.push_back('{hit, hit ? hd : mm[la[7:0]]});
    if (drain) wq.push_back(sbq[0]);
    fbusy = fbusy ? (n != 0) : (fl && n > 0);
    stall = drain ? 0 : (n > 0 ? stall + 1 : stall);
    if (drain) begin
      mm[sbq[0].a[7:0]] = sbq[0].d;
      void'(sbq.pop_front());
    end
    if (acc) sbq.push_back('{sa, sd});
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    st_valid = 0; ld_valid = 0; flush = 0; st_addr = 0; st_data = 0; ld_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 32'hC0DE_0000 | i;
      mm[i] = 32'hC0DE_0000 | i;
    end
    repeat (2) @(posedge clk);
    #1 RST = 1;
    // reset state and a plain miss
    step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 0, 0, 0);
    // duplicate-address forwarding, youngest wins
    step(1, 3, 32'hAAAA, 1, 3, 0);
    step(1, 3, 32'hBBBB, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    // fill under continuous misses until the forced drain
    for (int i = 0; i < 9; i++) step(1, 32'h20 + i, 32'h1000 + i, 1, 200, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    // count=2 then stores with drains, wrapping pointers
    step(1, 40, 32'h4000, 1, 201, 0);
    step(1, 41, 32'h4001, 1, 201, 0);
    for (int i = 0; i < 10; i++) step(1, 50 + i, 32'h5000 + i, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // flush with 3 entries while stores keep trying
    for (int i = 0; i < 3; i++) step(1, 70 + i, 32'h7000 + i, 1, 202, 0);
    for (int i = 0; i < 5; i++) step(1, 80 + i, 32'h8000 + i, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    // async reset while two entries are buffered
    step(1, 90, 32'h9000, 1, 203, 0);
    step(1, 91, 32'h9001, 1, 203, 0);
    idle_in();
    #2 RST = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_flush_busy", flush_busy, 0);
    sbq.delete(); sq.delete(); lq.delete(); wq.delete();
    stall = 0; fbusy = 0;
    @(posedge clk); #1 RST = 1;
    step(0, 0, 0, 1, 90, 0);
    step(0, 0, 0, 1, 91, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom % 2, $urandom % 8, $urandom, ($urandom % 4) != 0, $urandom % 12, ($urandom % 16) == 0);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("model_empty", sbq.size(), 0);
    chk("status_left", sq.size(), 0);
    chk("loads_left", lq.size(), 0);
    chk("writes_left", wq.size(), 0);
    for (int i = 0; i < 100; i++) chk($sformatf("mem[%0d]", i), bmem[i], mm[i]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer directly upstream of the word-addressed data memory in the MIPS datapath.
- Accepts stores from the CPU into a small in-order FIFO and drains one entry per cycle into the memory write port.
- Loads share the memory's single address port: a load that matches a buffered store gets that store's data forwarded; otherwise it reads the memory combinationally.
- A flush input drains the buffer completely before new stores are accepted.

Parameters:
- DataWidth, 32, width of data and address words.
- Depth, 4, number of buffer entries (power of two, >=2).
- MaxStall, 4, consecutive blocked-drain cycles allowed before the drain takes priority over a load miss.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- st_valid  input  1  store request.
- st_addr  input  DataWidth  store word address.
- st_data  input  DataWidth  store data.
- st_ready  output  1  store accepted this cycle when st_valid&&st_ready.
- ld_valid  input  1  load request.
- ld_addr  input  DataWidth  load word address.
- ld_ready  output  1  load completes this cycle when ld_valid&&ld_ready.
- ld_data  output  DataWidth  load result (combinational).
- ld_hit  output  1  ld_data came from the buffer.
- flush  input  1  level request to drain all entries.
- flush_busy  output  1  flush is in progress.
- mem_addr  output  DataWidth  drives memory address.
- mem_wdata  output  DataWidth  drives memory write data.
- mem_we  output  1  drives memory write enable.
- mem_rdata  input  DataWidth  memory read data (combinational).
- count  output  clog2(Depth)+1  number of occupied entries.

Behaviour:
- Reset (RST low, async): head/tail pointers=0, count=0, stall counter=0, flush state cleared, all entry valid bits=0.
- Output values immediately after reset: st_ready=1, mem_we=0, flush_busy=0, ld_hit=0. Entry data contents are don't-care.
- st_ready = !full && !flush_busy.
  - No same-cycle pass-through: a store is never accepted when full, even if a drain happens that cycle.
- Store accept: entry written at tail on the posedge; tail++ with wrap at Depth.
  - Duplicate addresses are enqueued separately; there is no merging.
- Load match: compare ld_addr with all valid entries. The youngest matching entry wins.
  - Hit: ld_hit=1, ld_data=entry data, ld_ready=1, memory port not used.
  - Miss: ld_data=mem_rdata, mem_addr=ld_addr, mem_we=0. ld_ready=1 unless the forced drain applies.
- Loads see buffer state before the current cycle's store acceptance; the current store is not forwarded.
- Drain (per cycle, when !empty):
  - Drain happens when the port is free: no ld_valid, or ld_valid with a hit, or the forced drain applies.
  - Drain drives mem_we=1, mem_addr=head.addr, mem_wdata=head.data, then head++ and count-- on the posedge.
  - Simultaneous accept and drain leaves count unchanged.
- Stall counter:
  - Increments each cycle !empty and the drain is blocked by a load miss.
  - Clears on any drain.
  - When it equals MaxStall, the forced drain applies: the drain wins the port, ld_ready=0, and the load retries.
  - Bound: at most MaxStall consecutive load-miss cycles can starve the buffer.
- Flush FSM:
  - IDLE -> DRAIN when flush=1 and !empty; stays IDLE if already empty.
  - DRAIN -> IDLE when count reaches 0.
  - flush_busy=1 in DRAIN. Stores are blocked; loads are still served under the normal rules.
- Reset mid-drain discards all entries; the team accepts data loss on reset.
- Default mem_addr when idle: mem_addr=ld_addr, mem_wdata=0, mem_we=0.

Decomposition:
- Shared constants header: entry field widths, and flush FSM state encodings IDLE=1'b0, DRAIN=1'b1.
- Sub-module store_buffer_match:
  - Purely combinational.
  - Takes the valid bits, address array, tail pointer and ld_addr.
  - Returns hit and the index of the youngest match, using an age order relative to tail.
- Top level holds the storage, pointers, stall counter, flush FSM and port muxing.

Test Plan:
- Reset then idle: st_ready=1, count=0, mem_we=0. A load of addr 5 returns mem_rdata, ld_hit=0.
- Store (3,0xAAAA) then (3,0xBBBB) back-to-back, then a load of 3 before the drain: ld_hit=1, ld_data=0xBBBB. After the drains, memory[3]=0xBBBB and the writes occurred in order.
- Fill Depth=4 entries while ld_valid misses every cycle: st_ready=0 at count=4. After 4 blocked cycles ld_ready=0 for one cycle, and mem_we=1 writes the head entry.
- Store and drain in the same cycle at count=2: count stays 2. Pointers wrap correctly after 10 stores to distinct addresses, and memory holds all 10 values.
- Assert flush with 3 entries: flush_busy=1 for 3 cycles and st_valid is refused. flush_busy drops when count=0, and st_ready returns to 1 the next cycle.
- Drop RST low mid-drain with 2 entries: count=0, mem_we=0 immediately (async). After release, a load of a previously buffered address returns mem_rdata.
